// File: rtl/hdmiin_fbuf_sched.sv
// ---------------------------------------------------------------------------
// hdmiin_fbuf_sched
// Triple-buffer scheduler between the HDMI-input copy engine (writer) and the
// video output scan engine (reader). Three frame-buffer slots are rotated so
// that the writer never overwrites the frame on screen and the reader only
// ever picks up complete frames.
//
// Ports:
//   i_clk          bus clock
//   i_reset_n      asynchronous active-low reset
//   i_en           scheduler enable; rising edge starts configuration
//   i_base_addr    word address of slot 0
//   i_frame_words  words per frame (slot k base = base + k*frame_words)
//   i_wr_sof       writer start-of-frame pulse
//   i_wr_eof       writer end-of-frame pulse
//   i_rd_sof       reader start-of-frame pulse
//   o_ready        configuration complete, scheduler running
//   o_wr_en        writer may store pixels into o_wr_addr
//   o_wr_addr      base of writer slot
//   o_rd_valid     a complete frame has been delivered to the reader
//   o_rd_addr      base of reader slot
//   o_frames       completed frames (saturating)
//   o_drops        complete frames overwritten before being read (saturating)
// ---------------------------------------------------------------------------
module hdmiin_fbuf_sched #(
    parameter int AW = 30,
    parameter int CW = 16
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_en,
    input  logic [AW-1:0] i_base_addr,
    input  logic [AW-1:0] i_frame_words,
    input  logic          i_wr_sof,
    input  logic          i_wr_eof,
    input  logic          i_rd_sof,
    output logic          o_ready,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr,
    output logic          o_rd_valid,
    output logic [AW-1:0] o_rd_addr,
    output logic [CW-1:0] o_frames,
    output logic [CW-1:0] o_drops
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CFG0 = 2'd1,
        ST_CFG1 = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_t        state_r, state_nxt_s;
    logic [AW-1:0] addr0_r, addr1_r, addr2_r;
    logic [AW-1:0] addr0_nxt_s, addr1_nxt_s, addr2_nxt_s;
    logic [1:0]    w_r, r_r, f_r;
    logic [1:0]    w_nxt_s, r_nxt_s, f_nxt_s;
    logic          fresh_r, fresh_nxt_s;
    logic          wr_en_r, wr_en_nxt_s;
    logic          rd_valid_r, rd_valid_nxt_s;
    logic          ready_r;
    logic [AW-1:0] wr_addr_r, rd_addr_r;
    logic [CW-1:0] frames_r, frames_nxt_s;
    logic [CW-1:0] drops_r, drops_nxt_s;
    logic [1:0]    tmp_idx_s;

    // Slot index to base address; an illegal index selects address zero.
    function automatic logic [AW-1:0] slot_addr(input logic [1:0]    idx,
                                                input logic [AW-1:0] a0,
                                                input logic [AW-1:0] a1,
                                                input logic [AW-1:0] a2);
        logic [AW-1:0] res;
        case (idx)
            2'd0:    res = a0;
            2'd1:    res = a1;
            2'd2:    res = a2;
            default: res = {AW{1'b0}};
        endcase
        return res;
    endfunction

    // Saturating increment for the frame/drop counters.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        logic [CW-1:0] res;
        if (v == CNT_MAX) begin
            res = v;
        end else begin
            res = v + CNT_ONE;
        end
        return res;
    endfunction

    // Next-state logic; dropping i_en always returns to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        if (!i_en) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = ST_CFG0;
                ST_CFG0: state_nxt_s = ST_CFG1;
                ST_CFG1: state_nxt_s = ST_RUN;
                ST_RUN:  state_nxt_s = ST_RUN;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Datapath: address configuration and slot rotation on frame events.
    always_comb begin
        addr0_nxt_s    = addr0_r;
        addr1_nxt_s    = addr1_r;
        addr2_nxt_s    = addr2_r;
        w_nxt_s        = w_r;
        r_nxt_s        = r_r;
        f_nxt_s        = f_r;
        fresh_nxt_s    = fresh_r;
        wr_en_nxt_s    = wr_en_r;
        rd_valid_nxt_s = rd_valid_r;
        frames_nxt_s   = frames_r;
        drops_nxt_s    = drops_r;
        tmp_idx_s      = 2'd0;
        if (!i_en) begin
            addr0_nxt_s    = {AW{1'b0}};
            addr1_nxt_s    = {AW{1'b0}};
            addr2_nxt_s    = {AW{1'b0}};
            w_nxt_s        = 2'd0;
            r_nxt_s        = 2'd1;
            f_nxt_s        = 2'd2;
            fresh_nxt_s    = 1'b0;
            wr_en_nxt_s    = 1'b0;
            rd_valid_nxt_s = 1'b0;
            frames_nxt_s   = {CW{1'b0}};
            drops_nxt_s    = {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    fresh_nxt_s = fresh_r;
                end
                ST_CFG0: begin
                    addr0_nxt_s = i_base_addr;
                    addr1_nxt_s = i_base_addr + i_frame_words;
                end
                ST_CFG1: begin
                    addr2_nxt_s = addr1_r + i_frame_words;
                end
                ST_RUN: begin
                    // Writer completion is applied first so a same-cycle
                    // reader SOF picks up the frame that just finished.
                    if (i_wr_eof && wr_en_r) begin
                        tmp_idx_s    = w_nxt_s;
                        w_nxt_s      = f_nxt_s;
                        f_nxt_s      = tmp_idx_s;
                        fresh_nxt_s  = 1'b1;
                        wr_en_nxt_s  = 1'b0;
                        frames_nxt_s = sat_inc(frames_r);
                        if (fresh_r) begin
                            drops_nxt_s = sat_inc(drops_r);
                        end else begin
                            drops_nxt_s = drops_r;
                        end
                    end else begin
                        tmp_idx_s = 2'd0;
                    end
                    if (i_rd_sof && fresh_nxt_s) begin
                        tmp_idx_s      = r_nxt_s;
                        r_nxt_s        = f_nxt_s;
                        f_nxt_s        = tmp_idx_s;
                        fresh_nxt_s    = 1'b0;
                        rd_valid_nxt_s = 1'b1;
                    end else begin
                        rd_valid_nxt_s = rd_valid_r;
                    end
                    // A repeated SOF abandons the frame in place.
                    if (i_wr_sof) begin
                        wr_en_nxt_s = 1'b1;
                    end else begin
                        wr_en_nxt_s = wr_en_nxt_s;
                    end
                end
                default: begin
                    fresh_nxt_s = fresh_r;
                end
            endcase
        end
    end

    // State, slot bookkeeping and registered outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r    <= ST_IDLE;
            addr0_r    <= {AW{1'b0}};
            addr1_r    <= {AW{1'b0}};
            addr2_r    <= {AW{1'b0}};
            w_r        <= 2'd0;
            r_r        <= 2'd1;
            f_r        <= 2'd2;
            fresh_r    <= 1'b0;
            wr_en_r    <= 1'b0;
            rd_valid_r <= 1'b0;
            ready_r    <= 1'b0;
            wr_addr_r  <= {AW{1'b0}};
            rd_addr_r  <= {AW{1'b0}};
            frames_r   <= {CW{1'b0}};
            drops_r    <= {CW{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            addr0_r    <= addr0_nxt_s;
            addr1_r    <= addr1_nxt_s;
            addr2_r    <= addr2_nxt_s;
            w_r        <= w_nxt_s;
            r_r        <= r_nxt_s;
            f_r        <= f_nxt_s;
            fresh_r    <= fresh_nxt_s;
            wr_en_r    <= wr_en_nxt_s;
            rd_valid_r <= rd_valid_nxt_s;
            ready_r    <= (state_nxt_s == ST_RUN);
            wr_addr_r  <= slot_addr(w_nxt_s, addr0_nxt_s, addr1_nxt_s, addr2_nxt_s);
            rd_addr_r  <= slot_addr(r_nxt_s, addr0_nxt_s, addr1_nxt_s, addr2_nxt_s);
            frames_r   <= frames_nxt_s;
            drops_r    <= drops_nxt_s;
        end
    end

    assign o_ready    = ready_r;
    assign o_wr_en    = wr_en_r;
    assign o_wr_addr  = wr_addr_r;
    assign o_rd_valid = rd_valid_r;
    assign o_rd_addr  = rd_addr_r;
    assign o_frames   = frames_r;
    assign o_drops    = drops_r;

endmodule

// File: tb/tb_hdmiin_fbuf_sched.sv
// ---------------------------------------------------------------------------
// tb_hdmiin_fbuf_sched
// Directed self-checking bench for the triple-buffer scheduler. Inputs change
// 1 ns after a rising edge and outputs are sampled at the same point, so each
// step() shows the effect of the previous edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hdmiin_fbuf_sched;

    localparam int AW = 30;
    localparam int CW = 16;

    logic          i_clk;
    logic          i_reset_n;
    logic          i_en;
    logic [AW-1:0] i_base_addr;
    logic [AW-1:0] i_frame_words;
    logic          i_wr_sof;
    logic          i_wr_eof;
    logic          i_rd_sof;
    logic          o_ready;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic          o_rd_valid;
    logic [AW-1:0] o_rd_addr;
    logic [CW-1:0] o_frames;
    logic [CW-1:0] o_drops;

    int tests;
    int fails;

    hdmiin_fbuf_sched #(.AW(AW), .CW(CW)) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_en          (i_en),
        .i_base_addr   (i_base_addr),
        .i_frame_words (i_frame_words),
        .i_wr_sof      (i_wr_sof),
        .i_wr_eof      (i_wr_eof),
        .i_rd_sof      (i_rd_sof),
        .o_ready       (o_ready),
        .o_wr_en       (o_wr_en),
        .o_wr_addr     (o_wr_addr),
        .o_rd_valid    (o_rd_valid),
        .o_rd_addr     (o_rd_addr),
        .o_frames      (o_frames),
        .o_drops       (o_drops)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Apply a set of event pulses for exactly one clock edge.
    task automatic pulse(input logic wsof, input logic weof, input logic rsof);
        i_wr_sof = wsof;
        i_wr_eof = weof;
        i_rd_sof = rsof;
        step();
        i_wr_sof = 1'b0;
        i_wr_eof = 1'b0;
        i_rd_sof = 1'b0;
    endtask

    // Drop enable for one cycle, then configure and wait for RUN.
    task automatic start(input logic [AW-1:0] base, input logic [AW-1:0] fw);
        i_en = 1'b0;
        step();
        i_base_addr   = base;
        i_frame_words = fw;
        i_en          = 1'b1;
        step();
        step();
        step();
    endtask

    task automatic test_reset();
        tests++;
        if ({o_ready, o_wr_en, o_wr_addr, o_rd_valid, o_rd_addr, o_frames, o_drops} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got rdy=%0b wen=%0b wa=%h rv=%0b ra=%h fr=%0d dr=%0d, want all 0",
                     o_ready, o_wr_en, o_wr_addr, o_rd_valid, o_rd_addr, o_frames, o_drops);
        end
    endtask

    task automatic test_config();
        i_base_addr   = 30'h1000;
        i_frame_words = 30'h100;
        i_en          = 1'b1;
        step();
        tests++;
        if (o_ready !== 1'b0) begin fails++; $display("FAIL cfg_ready_c1: got %0b want 0", o_ready); end
        step();
        tests++;
        if (o_ready !== 1'b0) begin fails++; $display("FAIL cfg_ready_c2: got %0b want 0", o_ready); end
        step();
        tests++;
        if (o_ready !== 1'b1) begin fails++; $display("FAIL cfg_ready_c3: got %0b want 1", o_ready); end
        tests++;
        if (o_wr_addr !== 30'h1000) begin fails++; $display("FAIL cfg_wr_addr: got %h want 1000", o_wr_addr); end
        tests++;
        if (o_rd_addr !== 30'h1100) begin fails++; $display("FAIL cfg_rd_addr: got %h want 1100", o_rd_addr); end
        tests++;
        if (o_rd_valid !== 1'b0 || o_wr_en !== 1'b0) begin
            fails++; $display("FAIL cfg_flags: got rv=%0b wen=%0b want 0 0", o_rd_valid, o_wr_en);
        end
    endtask

    task automatic test_normal();
        pulse(1'b1, 1'b0, 1'b0);
        tests++;
        if (o_wr_en !== 1'b1) begin fails++; $display("FAIL norm_wr_en: got %0b want 1", o_wr_en); end
        pulse(1'b0, 1'b1, 1'b0);
        tests++;
        if (o_wr_addr !== 30'h1200 || o_wr_en !== 1'b0) begin
            fails++; $display("FAIL norm_eof: got wa=%h wen=%0b want 1200 0", o_wr_addr, o_wr_en);
        end
        tests++;
        if (o_rd_valid !== 1'b0 || o_rd_addr !== 30'h1100) begin
            fails++; $display("FAIL norm_rd_before: got rv=%0b ra=%h want 0 1100", o_rd_valid, o_rd_addr);
        end
        pulse(1'b0, 1'b0, 1'b1);
        tests++;
        if (o_rd_addr !== 30'h1000 || o_rd_valid !== 1'b1) begin
            fails++; $display("FAIL norm_rd_sof: got ra=%h rv=%0b want 1000 1", o_rd_addr, o_rd_valid);
        end
        tests++;
        if (o_frames !== 16'd1 || o_drops !== 16'd0 || o_wr_addr !== 30'h1200) begin
            fails++; $display("FAIL norm_counts: got fr=%0d dr=%0d wa=%h want 1 0 1200", o_frames, o_drops, o_wr_addr);
        end
    endtask

    task automatic test_overrun();
        start(30'h1000, 30'h100);
        tests++;
        if (o_frames !== 16'd0 || o_rd_valid !== 1'b0 || o_wr_addr !== 30'h1000) begin
            fails++; $display("FAIL ovr_restart: got fr=%0d rv=%0b wa=%h want 0 0 1000", o_frames, o_rd_valid, o_wr_addr);
        end
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        tests++;
        if (o_wr_addr !== 30'h1200 || o_frames !== 16'd1 || o_drops !== 16'd0) begin
            fails++; $display("FAIL ovr_frame1: got wa=%h fr=%0d dr=%0d want 1200 1 0", o_wr_addr, o_frames, o_drops);
        end
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        tests++;
        if (o_wr_addr !== 30'h1000 || o_frames !== 16'd2 || o_drops !== 16'd1) begin
            fails++; $display("FAIL ovr_frame2: got wa=%h fr=%0d dr=%0d want 1000 2 1", o_wr_addr, o_frames, o_drops);
        end
        tests++;
        if (o_rd_addr !== 30'h1100 || o_rd_valid !== 1'b0) begin
            fails++; $display("FAIL ovr_rd: got ra=%h rv=%0b want 1100 0", o_rd_addr, o_rd_valid);
        end
    endtask

    task automatic test_simultaneous();
        start(30'h1000, 30'h100);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b1);
        tests++;
        if (o_rd_addr !== 30'h1000 || o_wr_addr !== 30'h1200 || o_rd_valid !== 1'b1) begin
            fails++; $display("FAIL sim_swap: got ra=%h wa=%h rv=%0b want 1000 1200 1", o_rd_addr, o_wr_addr, o_rd_valid);
        end
        tests++;
        if (o_frames !== 16'd1 || o_drops !== 16'd0) begin
            fails++; $display("FAIL sim_counts: got fr=%0d dr=%0d want 1 0", o_frames, o_drops);
        end
        pulse(1'b0, 1'b0, 1'b1);
        tests++;
        if (o_rd_addr !== 30'h1000 || o_wr_addr !== 30'h1200) begin
            fails++; $display("FAIL sim_repeat: got ra=%h wa=%h want 1000 1200", o_rd_addr, o_wr_addr);
        end
    endtask

    task automatic test_abandon();
        start(30'h1000, 30'h100);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        tests++;
        if (o_wr_addr !== 30'h1000 || o_wr_en !== 1'b1 || o_frames !== 16'd0) begin
            fails++; $display("FAIL abn_second_sof: got wa=%h wen=%0b fr=%0d want 1000 1 0", o_wr_addr, o_wr_en, o_frames);
        end
        pulse(1'b0, 1'b1, 1'b0);
        tests++;
        if (o_wr_addr !== 30'h1200 || o_frames !== 16'd1 || o_wr_en !== 1'b0) begin
            fails++; $display("FAIL abn_eof: got wa=%h fr=%0d wen=%0b want 1200 1 0", o_wr_addr, o_frames, o_wr_en);
        end
    endtask

    // Continues from the abandon state: W=2, F=0, fresh=1.
    task automatic test_back_to_back();
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b1, 1'b0);
        tests++;
        if (o_wr_en !== 1'b1 || o_wr_addr !== 30'h1000) begin
            fails++; $display("FAIL b2b_wr: got wen=%0b wa=%h want 1 1000", o_wr_en, o_wr_addr);
        end
        tests++;
        if (o_frames !== 16'd2 || o_drops !== 16'd1) begin
            fails++; $display("FAIL b2b_counts: got fr=%0d dr=%0d want 2 1", o_frames, o_drops);
        end
    endtask

    task automatic test_abort_en();
        i_en = 1'b0;
        step();
        tests++;
        if ({o_ready, o_wr_en, o_wr_addr, o_rd_valid, o_rd_addr, o_frames, o_drops} !== '0) begin
            fails++; $display("FAIL abort_en: got rdy=%0b wen=%0b wa=%h fr=%0d dr=%0d want all 0",
                              o_ready, o_wr_en, o_wr_addr, o_frames, o_drops);
        end
        pulse(1'b1, 1'b0, 1'b0);
        tests++;
        if (o_wr_en !== 1'b0) begin fails++; $display("FAIL idle_ignore: got wen=%0b want 0", o_wr_en); end
        start(30'h1000, 30'h100);
        tests++;
        if (o_wr_addr !== 30'h1000 || o_rd_addr !== 30'h1100) begin
            fails++; $display("FAIL abort_slots: got wa=%h ra=%h want 1000 1100", o_wr_addr, o_rd_addr);
        end
    endtask

    task automatic test_async_reset();
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        #2;
        i_reset_n = 1'b0;
        #1;
        tests++;
        if ({o_ready, o_wr_en, o_wr_addr, o_rd_valid, o_rd_addr, o_frames, o_drops} !== '0) begin
            fails++; $display("FAIL async_reset: got rdy=%0b wa=%h ra=%h fr=%0d want all 0",
                              o_ready, o_wr_addr, o_rd_addr, o_frames);
        end
        step();
        i_reset_n = 1'b1;
        step();
        tests++;
        if (o_ready !== 1'b0) begin fails++; $display("FAIL rst_cfg_c1: got %0b want 0", o_ready); end
        step();
        tests++;
        if (o_ready !== 1'b0) begin fails++; $display("FAIL rst_cfg_c2: got %0b want 0", o_ready); end
        step();
        tests++;
        if (o_ready !== 1'b1 || o_wr_addr !== 30'h1000 || o_rd_addr !== 30'h1100) begin
            fails++; $display("FAIL rst_cfg_c3: got rdy=%0b wa=%h ra=%h want 1 1000 1100", o_ready, o_wr_addr, o_rd_addr);
        end
    endtask

    task automatic test_wrap();
        start(30'h3FFFFF80, 30'h80);
        tests++;
        if (o_wr_addr !== 30'h3FFFFF80 || o_rd_addr !== 30'h0) begin
            fails++; $display("FAIL wrap_addr01: got wa=%h ra=%h want 3fffff80 0", o_wr_addr, o_rd_addr);
        end
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        tests++;
        if (o_wr_addr !== 30'h80) begin fails++; $display("FAIL wrap_addr2: got %h want 80", o_wr_addr); end
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        i_reset_n     = 1'b0;
        i_en          = 1'b0;
        i_base_addr   = '0;
        i_frame_words = '0;
        i_wr_sof      = 1'b0;
        i_wr_eof      = 1'b0;
        i_rd_sof      = 1'b0;
        #12;
        test_reset();
        #10;
        i_reset_n = 1'b1;
        step();
        test_config();
        test_normal();
        test_overrun();
        test_simultaneous();
        test_abandon();
        test_back_to_back();
        test_abort_en();
        test_async_reset();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hdmiin_fbuf_sched.md
Name: hdmiin_fbuf_sched

Overview:
- Triple-buffer scheduler between the HDMI-input copy engine (writer) and the video output scan engine (reader).
- Owns three frame-buffer slots in memory; hands the writer a slot to fill and the reader the newest complete frame.
- The writer never overwrites the frame being displayed, and the reader never sees a partial frame.
- Single clock (bus clock); frame events arrive already synchronized to that clock.

Parameters:
AW, 30, word-address width of buffer base addresses and frame size.
CW, 16, width of completed-frame and dropped-frame counters.

Ports:
i_clk  input  1  bus clock
i_reset_n  input  1  asynchronous active-low reset
i_en  input  1  scheduler enable; rising edge latches configuration
i_base_addr  input  AW  word address of slot 0
i_frame_words  input  AW  words per frame; slot k base = i_base_addr + k*i_frame_words
i_wr_sof  input  1  writer start-of-frame pulse
i_wr_eof  input  1  writer end-of-frame pulse (frame fully written)
i_rd_sof  input  1  reader start-of-frame pulse (about to scan a frame)
o_ready  output  1  configuration complete, scheduler running
o_wr_en  output  1  writer permitted to store pixels into o_wr_addr
o_wr_addr  output  AW  base of writer slot
o_rd_valid  output  1  at least one complete frame delivered to reader since enable
o_rd_addr  output  AW  base of reader slot
o_frames  output  CW  completed frames, saturating
o_drops  output  CW  complete frames overwritten before being read, saturating

Behaviour:
- Reset value of every output: 0. Internal slot indices W=0, R=1, F=2; fresh=0; state IDLE.
- States: IDLE -> CFG0 -> CFG1 -> RUN. IDLE: wait for i_en=1.
- CFG0: addr0<=base, addr1<=base+fw (inputs sampled this cycle).
- CFG1: addr2<=addr1+fw. Sums wrap modulo 2^AW.
- RUN: o_ready=1.
- i_en=0 in any state -> IDLE next cycle. Outputs and counters cleared; slot indices reset to W=0, R=1, F=2; fresh=0.
- Slots {W,R,F} are always a permutation of {0,1,2}. o_wr_addr=addr[W], o_rd_addr=addr[R], both registered.
- All updates are visible 1 cycle after the triggering pulse. Events are ignored outside RUN.
- i_wr_sof: o_wr_en<=1. If already 1 (no eof since last sof), the frame is abandoned: W unchanged, no count.
- i_wr_eof with o_wr_en=1:
  - swap W<->F; fresh<=1; o_wr_en<=0; o_frames++.
  - If fresh was already 1, o_drops++.
- i_wr_eof with o_wr_en=0: ignored.
- i_rd_sof with fresh=1: swap R<->F; fresh<=0; o_rd_valid<=1.
- i_rd_sof with fresh=0: no change; the reader repeats its frame.
- Simultaneous i_wr_eof and i_rd_sof: the writer swap is applied first, then the reader swap, in the same cycle.
  - Net result: W'=F, R'=W, F'=R, fresh'=0.
  - The reader gets the just-completed frame; o_drops increments only if fresh was 1 before.
- Simultaneous i_wr_sof and i_wr_eof: eof processed first, then sof. Net o_wr_en=1 on the new W slot.
- Counters saturate at all-ones.
- Asynchronous reset mid-operation forces reset values immediately. The first RUN after reset requires a full CFG0/CFG1 pass.

Test Plan:
- Config: base=0x1000, fw=0x100, raise i_en -> o_ready=1 on 3rd cycle; o_wr_addr=0x1000, o_rd_addr=0x1100; o_rd_valid=0.
- Normal flow: wr_sof, wr_eof, then rd_sof -> o_wr_addr=0x1200 after eof; o_rd_addr=0x1000 after rd_sof; o_frames=1, o_drops=0, o_rd_valid=1.
- Overrun: two full writer frames with no rd_sof:
  - o_frames=2, o_drops=1.
  - Writer slots alternate 0x1000->0x1200->0x1000; o_rd_addr stays 0x1100.
- Simultaneous wr_eof+rd_sof after the first sof:
  - o_rd_addr=0x1000, o_wr_addr=0x1200, fresh cleared.
  - A following rd_sof leaves o_rd_addr unchanged.
- Abandon: wr_sof, wr_sof, wr_eof -> o_frames=1; o_wr_addr unchanged until eof.
- Abort: drop i_en mid-frame, or pulse i_reset_n low -> all outputs 0 and slots reset. Wrap check: base=0x3FFFFF80, fw=0x80 gives addr1=0, addr2=0x80.
